cve2_mem_arbiter: RTL
=====================

CVE2_MEM_ARBITER -- requirements
Module: cve2_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, giving the maximum number of granted transactions awaiting rvalid (legal range 1..4).
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1  (core fetch port, req/gnt/rvalid protocol).
REQ-005 SHALL have ports data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1  (core LSU port).
REQ-006 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1  (shared memory port).
REQ-007 SHALL have port protocol_err_o  output  1  sticky flag: unexpected mem_rvalid_i.

Function
REQ-008 SHALL assert mem_req_o only when some requester is active and outstanding count < MaxOutstanding; a push is never accepted at full, even with a same-cycle pop.
REQ-009 SHALL drive the mem_* request fields from the selected requester; instruction requests SHALL drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-010 SHALL assert instr_gnt_o/data_gnt_o combinationally as mem_gnt_i AND mem_req_o AND (selected source), at most one grant per cycle.
REQ-011 SHALL lock the selection while mem_req_o=1 and mem_gnt_i=0, so mem_* fields stay stable until grant; the lock clears on grant, or when the locked requester drops its request (the other requester is then selectable in that same cycle).
REQ-012 SHALL push the granted source id into an in-order ownership FIFO on every mem_req_o&&mem_gnt_i cycle.
REQ-013 SHALL, on mem_rvalid_i with a non-empty FIFO, pop the head and pulse exactly one of instr_rvalid_o/data_rvalid_o in the same cycle (zero latency), with mem_rdata_i/mem_err_i forwarded.
REQ-014 SHALL drive rdata/err outputs of the non-selected requester to 0.
REQ-015 SHALL, on mem_rvalid_i with empty FIFO, drop the response, pulse no rvalid, and set protocol_err_o until reset.
REQ-016 SHALL support same-cycle push and pop (count unchanged, head advances); the FIFO pointers wrap modulo MaxOutstanding.
REQ-017 SHALL arbitrate simultaneous unlocked requests per REQ-022.

Reset
REQ-018 SHALL, on rst_ni=0 (any cycle, mid-transaction included), immediately empty the FIFO, clear the count, lock and protocol_err_o, and set last-granted=instruction.
REQ-019 SHALL hold all outputs at 0 during reset; responses to transactions granted before reset SHALL be treated per REQ-015.

Configuration
REQ-020 SHALL use macro CVE2_ARB_RR_EN to select the arbitration policy.
REQ-021 SHALL, without CVE2_ARB_RR_EN, give data fixed priority over instruction on conflict.
REQ-022 SHALL, with CVE2_ARB_RR_EN, grant the source not granted last on conflict; last-granted updates on each grant; the first conflict after reset goes to data.

Structure
REQ-023 SHALL place typedef arb_src_e (ARB_SRC_INSTR=1'b0, ARB_SRC_DATA=1'b1) and constant ArbMaxOutstandingLimit=4 in shared package cve2_arb_pkg.
REQ-024 SHALL implement the ownership FIFO as sub-module cve2_arb_order_fifo (push, pop, full, empty, head).

Verification
REQ-025 Both requesting, mem_gnt_i=1 every cycle, no macro -> data granted for 3 consecutive cycles while data_req_i stays 1, instr_gnt_o=0.
REQ-026 Same stimulus with CVE2_ARB_RR_EN -> grants alternate data, instr, data, instr.
REQ-027 instr request 0x0000_0100 granted, then data read 0x2000_0000 granted, rvalids return with rdata 0xAAAA_AAAA then 0x5555_5555 -> instr_rvalid_o with 0xAAAA_AAAA first, then data_rvalid_o with 0x5555_5555.
REQ-028 MaxOutstanding=2, two grants and no rvalid -> mem_req_o=0 in the third cycle; one rvalid -> mem_req_o=1 on the next cycle.
REQ-029 mem_gnt_i=0 for 4 cycles with instr locked, data_req_i rising in cycle 2 -> mem_addr_o held at the instr address all 4 cycles.
REQ-030 mem_rvalid_i pulse with FIFO empty -> no rvalid output and protocol_err_o=1; rst_ni low -> protocol_err_o=0 and FIFO empty.

Source files
------------

// File: rtl/cve2_arb_pkg.sv
// Shared types and constants for the CVE2 instruction/data memory arbiter.
package cve2_arb_pkg;

    // Identifies which core port owns a memory transaction.
    typedef enum logic {
        ARB_SRC_INSTR = 1'b0,
        ARB_SRC_DATA  = 1'b1
    } arb_src_e;

    // Upper bound for the MaxOutstanding parameter of the arbiter.
    localparam int unsigned ArbMaxOutstandingLimit = 4;

    // Pointer and occupancy widths sized for the upper bound.
    localparam int unsigned ArbPtrW = 2;
    localparam int unsigned ArbCntW = 3;

    // Advance a FIFO pointer, wrapping at the configured depth rather than
    // at the power of two, so depths of 1 and 3 work too.
    function automatic logic [ArbPtrW-1:0] arb_ptr_inc(
        input logic [ArbPtrW-1:0] ptr,
        input int unsigned        depth
    );
        if (32'(ptr) + 32'd1 >= depth) begin
            return '0;
        end
        return ptr + ArbPtrW'(1);
    endfunction

endpackage

// File: rtl/cve2_arb_order_fifo.sv
// In-order ownership FIFO: remembers which port issued each granted memory
// transaction so responses can be routed back in order.
module cve2_arb_order_fifo
    import cve2_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic push_src_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    logic [ArbMaxOutstandingLimit-1:0] r_mem;
    logic [ArbPtrW-1:0]                r_wr_ptr;
    logic [ArbPtrW-1:0]                r_rd_ptr;
    logic [ArbCntW-1:0]                r_count;
    logic                              w_push;
    logic                              w_pop;

    assign full_o  = (r_count == ArbCntW'(Depth));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= arb_ptr_inc(r_wr_ptr, Depth);
            end
            if (w_pop) begin
                r_rd_ptr <= arb_ptr_inc(r_rd_ptr, Depth);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ArbCntW'(1);
                2'b01:   r_count <= r_count - ArbCntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Ownership storage, written at the tail on every accepted push.
    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, and the occupancy count guards that.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_src_i;
        end
    end

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Two-port (instruction fetch / LSU) to one-port memory arbiter with an
// outstanding-transaction limit and in-order response routing.
// Define CVE2_ARB_RR_EN for round-robin arbitration on conflict; without it
// the data port has fixed priority.
module cve2_mem_arbiter
    import cve2_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        protocol_err_o
);

    logic      r_locked;
    arb_src_e  r_lock_src;
    logic      r_protocol_err;
`ifdef CVE2_ARB_RR_EN
    arb_src_e  r_last_src;
`endif

    arb_src_e  w_sel_src;
    logic      w_mem_req;
    logic      w_grant;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic      w_head;

    // Requests stop at the outstanding limit; everything is silent in reset.
    assign w_mem_req = rst_ni && (instr_req_i || data_req_i) && !w_full;
    assign w_grant   = w_mem_req && mem_gnt_i;
    assign w_pop     = rst_ni && mem_rvalid_i && !w_empty;

    // Source selection: a still-requesting locked source wins, otherwise
    // arbitrate, otherwise take whichever port is requesting.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel_src = ARB_SRC_INSTR;
        if (r_locked && ((r_lock_src == ARB_SRC_DATA) ? data_req_i : instr_req_i)) begin
            w_sel_src = r_lock_src;
        end else if (instr_req_i && data_req_i) begin
`ifdef CVE2_ARB_RR_EN
            w_sel_src = (r_last_src == ARB_SRC_DATA) ? ARB_SRC_INSTR : ARB_SRC_DATA;
`else
            w_sel_src = ARB_SRC_DATA;
`endif
        end else if (data_req_i) begin
            w_sel_src = ARB_SRC_DATA;
        end
    end

    // Lock, last-granted and sticky protocol error state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_locked       <= 1'b0;
            r_lock_src     <= ARB_SRC_INSTR;
            r_protocol_err <= 1'b0;
`ifdef CVE2_ARB_RR_EN
            r_last_src     <= ARB_SRC_INSTR;
`endif
        end else begin
            // Holding the selection while a request waits keeps mem_* stable.
            r_locked   <= w_mem_req && !mem_gnt_i;
            r_lock_src <= w_sel_src;
            if (mem_rvalid_i && w_empty) begin
                r_protocol_err <= 1'b1;
            end
`ifdef CVE2_ARB_RR_EN
            if (w_grant) begin
                r_last_src <= w_sel_src;
            end
`endif
        end
    end

    // Request mux, grant steering and response routing.
    always_comb begin
        mem_req_o      = w_mem_req;
        mem_we_o       = 1'b0;
        mem_be_o       = 4'h0;
        mem_addr_o     = 32'h0;
        mem_wdata_o    = 32'h0;
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = 32'h0;
        instr_err_o    = 1'b0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = 32'h0;
        data_err_o     = 1'b0;

        if (w_mem_req) begin
            if (w_sel_src == ARB_SRC_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
                data_gnt_o  = mem_gnt_i;
            end else begin
                mem_be_o    = 4'hF;
                mem_addr_o  = instr_addr_i;
                instr_gnt_o = mem_gnt_i;
            end
        end

        if (w_pop) begin
            if (arb_src_e'(w_head) == ARB_SRC_DATA) begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = mem_rdata_i;
                data_err_o    = mem_err_i;
            end else begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = mem_rdata_i;
                instr_err_o    = mem_err_i;
            end
        end
    end

    assign protocol_err_o = r_protocol_err;

    cve2_arb_order_fifo #(
        .Depth (MaxOutstanding)
    ) u_order_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (w_grant),
        .push_src_i (w_sel_src),
        .pop_i      (w_pop),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .head_o     (w_head)
    );

endmodule
